board_engine: RTL and testbench
===============================

# board_engine

Othello board datapath that answers the game controller's command stream. On a `detect` pulse it decides whether the cursor square is a legal move for the side to play. On a `place` pulse it re-checks the move, writes the disk, flips every captured run and recounts the board. It reports `legal`, disk counts and `win` back to the controller. It also exposes a combinational read port so the VGA cell-drawing path can fetch any square.

## Interface
- No parameters; the board is fixed at 8x8.
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- new_game  in  1  synchronous clear to the opening position; aborts any operation in progress
- cur_x, cur_y  in  3 each  cursor column/row; sampled on the command-accept cycle only
- side  in  1  side to move: 0 = black, 1 = white; sampled on the command-accept cycle only
- detect  in  1  one-cycle command: legality check only
- place  in  1  one-cycle command: check, then place, flip and count
- rd_x, rd_y  in  3 each  read-port address
- rd_cell  out  2  combinational board contents at (rd_x, rd_y)
- busy  out  1  high while a command executes
- done  out  1  one-cycle pulse when a command completes
- legal  out  1  result of the last completed command; held until the next `done`
- black_count, white_count  out  7 each  disk totals after the last count pass
- win  out  1  game over: board full, or either count equals 0
- winner  out  2  valid when `win`=1: 01 black ahead, 10 white ahead, 11 tie

## Operation
- Cell encoding: 00 empty, 01 black, 10 white; 11 is never stored. The board is 64x2 flops.
- Opening position: (3,3) and (4,4) white; (4,3) and (3,4) black.
- FSM states: IDLE, SCAN, WRITE, FLIP, COUNT, FINISH.
- IDLE
  - Accepts `detect` or `place` when `busy`=0.
  - `place` has priority when both are asserted.
  - Latches x, y, side and the operation, then goes to SCAN.
- SCAN
  - Walks directions in the fixed order N, NE, E, SE, S, SW, W, NW. N is y-1; E is x+1.
  - Each direction starts at cursor+delta and visits one cell per cycle.
  - Opponent cell: increment `run` (3 bits) and continue.
  - Own cell with `run` ≥ 1: set `dir_mask[d]` and store `run[d]`.
  - Own cell with `run` = 0, an empty cell, or an off-board position: direction fails.
  - A direction always costs at least 1 cycle, even when the first step is off-board.
  - When NW ends, the result is `ok` = (cursor cell empty) AND (`dir_mask` ≠ 0).
  - If the cursor cell is occupied, `ok`=0; the directions are still scanned.
  - Next state: WRITE if the operation is place and `ok`=1; otherwise FINISH.
- WRITE (1 cycle): store the side's disk at the cursor.
- FLIP
  - For each set `dir_mask` bit, in direction order, overwrite `run[d]` cells with the side's colour.
  - Writes one cell per cycle.
- COUNT: iterates the 64 cells, one per cycle, into shadow counters; in its last cycle it loads `black_count`, `white_count`, `win` and `winner`.
- FINISH (1 cycle): `done`=1, `legal`=`ok`; then returns to IDLE.
- `detect` never modifies the board, counts or `win`.
- An illegal `place` behaves like `detect`: the board is unchanged and `legal`=0.
- `detect`/`place` asserted while `busy`=1 are ignored, not queued.
- `new_game`: the board goes to the opening position, counts to 2/2, `win`=0, `legal`=0 and the FSM to IDLE next cycle, with no `done`. `new_game` overrides a command asserted in the same cycle.

## Timing
- Reset values: board at the opening position, FSM in IDLE, `busy`=0, `done`=0, `legal`=0, `black_count`=2, `white_count`=2, `win`=0, `winner`=00.
- Command accepted at edge N; `busy`=1 from N+1 until the FINISH cycle inclusive. `busy`=0 in the cycle after `done`.
- SCAN takes S cycles, where 8 ≤ S ≤ 56.
- `detect` latency from accept to `done`: S+1 cycles, maximum 57.
- Legal `place` latency: S + 1 + F + 64 + 1 cycles, where F = total flipped cells (1 ≤ F ≤ 18).
- `rd_cell` has zero latency. During FLIP/COUNT it reflects writes made on previous edges.
- The controller holds in its wait state until `done`; it samples `legal` and `win` in the `done` cycle or later.

## Test plan
- Reset, then read all 64 cells → opening position, counts 2/2, `win`=0, `busy`=0.
- Opening `detect` black at (3,2) → one `done`, `legal`=1, board unchanged. Black at (0,0) → `legal`=0.
- Opening `place` black at (3,2) → (3,2) and (3,3) black, black_count=4, white_count=1, `legal`=1; latency = S+1+1+64+1.
- `place` on occupied (3,3) → `legal`=0, board and counts unchanged, latency S+1.
- Fill the board with white except (7,7) empty and (6,7) black, then `place` white at (7,7) → (6,7) flips to white; black_count=0, `win`=1, `winner`=10.
- Assert `new_game` mid-FLIP → no `done`, opening position restored next cycle. `detect` during `busy` → ignored, exactly one `done` observed.

Source files
------------

// File: rtl/board_engine.sv
// board_engine: Othello board datapath. Holds the 8x8 board, checks a
// cursor move for legality, places and flips disks, recounts the board,
// and offers a combinational read port for the display path.
module board_engine (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       new_game,
    input  logic [2:0] cur_x,
    input  logic [2:0] cur_y,
    input  logic       side,
    input  logic       detect,
    input  logic       place,
    input  logic [2:0] rd_x,
    input  logic [2:0] rd_y,
    output logic [1:0] rd_cell,
    output logic       busy,
    output logic       done,
    output logic       legal,
    output logic [6:0] black_count,
    output logic [6:0] white_count,
    output logic       win,
    output logic [1:0] winner
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SCAN   = 3'd1;
    localparam logic [2:0] ST_WRITE  = 3'd2;
    localparam logic [2:0] ST_FLIP   = 3'd3;
    localparam logic [2:0] ST_COUNT  = 3'd4;
    localparam logic [2:0] ST_FINISH = 3'd5;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BLACK = 2'b01;
    localparam logic [1:0] CELL_WHITE = 2'b10;

    // Column step for direction d (N, NE, E, SE, S, SW, W, NW), 5-bit two's complement
    function automatic logic [4:0] dir_dx(input logic [2:0] d);
        logic [4:0] r;
        case (d)
            3'd1, 3'd2, 3'd3: r = 5'b00001;
            3'd5, 3'd6, 3'd7: r = 5'b11111;
            default:          r = 5'b00000;
        endcase
        return r;
    endfunction

    // Row step for direction d; north is towards row 0
    function automatic logic [4:0] dir_dy(input logic [2:0] d);
        logic [4:0] r;
        case (d)
            3'd0, 3'd1, 3'd7: r = 5'b11111;
            3'd3, 3'd4, 3'd5: r = 5'b00001;
            default:          r = 5'b00000;
        endcase
        return r;
    endfunction

    // Lowest set bit of mask at index >= start; bit 3 of the result flags "found"
    function automatic logic [3:0] next_set(input logic [7:0] mask, input logic [3:0] start);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (i >= int'(start))) begin
                r = {1'b1, i[2:0]};
            end
        end
        return r;
    endfunction

    // Board index is y*8 + x
    function automatic logic [63:0][1:0] opening_board();
        logic [63:0][1:0] b;
        b     = '0;
        b[27] = CELL_WHITE;
        b[36] = CELL_WHITE;
        b[28] = CELL_BLACK;
        b[35] = CELL_BLACK;
        return b;
    endfunction

    logic [2:0]       state_q, state_d;
    logic [63:0][1:0] board_q, board_d;
    logic [2:0]       x_q, x_d;
    logic [2:0]       y_q, y_d;
    logic             side_q, side_d;
    logic             place_op_q, place_op_d;
    logic [2:0]       dir_q, dir_d;
    logic [2:0]       run_q, run_d;
    logic [4:0]       px_q, px_d;
    logic [4:0]       py_q, py_d;
    logic [7:0]       dir_mask_q, dir_mask_d;
    logic [7:0][2:0]  run_arr_q, run_arr_d;
    logic             ok_q, ok_d;
    logic [5:0]       cnt_idx_q, cnt_idx_d;
    logic [6:0]       shadow_black_q, shadow_black_d;
    logic [6:0]       shadow_white_q, shadow_white_d;
    logic             legal_q, legal_d;
    logic [6:0]       black_count_q, black_count_d;
    logic [6:0]       white_count_q, white_count_d;
    logic             win_q, win_d;
    logic [1:0]       winner_q, winner_d;

    logic       on_board;
    logic [5:0] pos_idx;
    logic [1:0] pos_cell;
    logic [5:0] cursor_idx;
    logic [1:0] own_cell;
    logic [1:0] opp_cell;
    logic [1:0] count_cell;
    logic [6:0] black_total;
    logic [6:0] white_total;
    logic       board_full;
    logic       game_over;
    logic [1:0] final_winner;
    logic [3:0] nxt_dir;
    logic [3:0] first_dir;

    assign on_board    = (px_q[4:3] == 2'b00) && (py_q[4:3] == 2'b00);
    assign pos_idx     = {py_q[2:0], px_q[2:0]};
    assign pos_cell    = board_q[pos_idx];
    assign cursor_idx  = {y_q, x_q};
    assign own_cell    = side_q ? CELL_WHITE : CELL_BLACK;
    assign opp_cell    = side_q ? CELL_BLACK : CELL_WHITE;
    assign count_cell  = board_q[cnt_idx_q];
    assign black_total = shadow_black_q + {6'd0, count_cell == CELL_BLACK};
    assign white_total = shadow_white_q + {6'd0, count_cell == CELL_WHITE};
    assign board_full  = ({1'b0, black_total} + {1'b0, white_total}) == 8'd64;
    assign game_over   = board_full || (black_total == 7'd0) || (white_total == 7'd0);
    assign final_winner = (black_total > white_total) ? 2'b01 :
                          (white_total > black_total) ? 2'b10 : 2'b11;
    assign nxt_dir     = next_set(dir_mask_q, {1'b0, dir_q} + 4'd1);
    assign first_dir   = next_set(dir_mask_q, 4'd0);

    // Command sequencing: scan directions, write, flip runs, recount, report
    always_comb begin
        state_d        = state_q;
        board_d        = board_q;
        x_d            = x_q;
        y_d            = y_q;
        side_d         = side_q;
        place_op_d     = place_op_q;
        dir_d          = dir_q;
        run_d          = run_q;
        px_d           = px_q;
        py_d           = py_q;
        dir_mask_d     = dir_mask_q;
        run_arr_d      = run_arr_q;
        ok_d           = ok_q;
        cnt_idx_d      = cnt_idx_q;
        shadow_black_d = shadow_black_q;
        shadow_white_d = shadow_white_q;
        legal_d        = legal_q;
        black_count_d  = black_count_q;
        white_count_d  = white_count_q;
        win_d          = win_q;
        winner_d       = winner_q;

        if (new_game) begin
            state_d       = ST_IDLE;
            board_d       = opening_board();
            legal_d       = 1'b0;
            black_count_d = 7'd2;
            white_count_d = 7'd2;
            win_d         = 1'b0;
            winner_d      = 2'b00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (place || detect) begin
                        state_d    = ST_SCAN;
                        x_d        = cur_x;
                        y_d        = cur_y;
                        side_d     = side;
                        place_op_d = place;
                        dir_d      = 3'd0;
                        run_d      = 3'd0;
                        dir_mask_d = 8'd0;
                        run_arr_d  = '0;
                        ok_d       = 1'b0;
                        px_d       = {2'b00, cur_x} + dir_dx(3'd0);
                        py_d       = {2'b00, cur_y} + dir_dy(3'd0);
                    end
                end

                ST_SCAN: begin
                    if (on_board && (pos_cell == opp_cell)) begin
                        run_d = run_q + 3'd1;
                        px_d  = px_q + dir_dx(dir_q);
                        py_d  = py_q + dir_dy(dir_q);
                    end else begin
                        if (on_board && (pos_cell == own_cell) && (run_q != 3'd0)) begin
                            dir_mask_d[dir_q] = 1'b1;
                            run_arr_d[dir_q]  = run_q;
                        end
                        if (dir_q == 3'd7) begin
                            ok_d = (board_q[cursor_idx] == CELL_EMPTY) && (dir_mask_d != 8'd0);
                            if (place_op_q && ok_d) begin
                                state_d = ST_WRITE;
                            end else begin
                                state_d = ST_FINISH;
                                legal_d = ok_d;
                            end
                        end else begin
                            dir_d = dir_q + 3'd1;
                            run_d = 3'd0;
                            px_d  = {2'b00, x_q} + dir_dx(dir_q + 3'd1);
                            py_d  = {2'b00, y_q} + dir_dy(dir_q + 3'd1);
                        end
                    end
                end

                ST_WRITE: begin
                    board_d[cursor_idx] = own_cell;
                    dir_d   = first_dir[2:0];
                    run_d   = 3'd1;
                    px_d    = {2'b00, x_q} + dir_dx(first_dir[2:0]);
                    py_d    = {2'b00, y_q} + dir_dy(first_dir[2:0]);
                    state_d = ST_FLIP;
                end

                ST_FLIP: begin
                    board_d[pos_idx] = own_cell;
                    if (run_q == run_arr_q[dir_q]) begin
                        if (nxt_dir[3]) begin
                            dir_d = nxt_dir[2:0];
                            run_d = 3'd1;
                            px_d  = {2'b00, x_q} + dir_dx(nxt_dir[2:0]);
                            py_d  = {2'b00, y_q} + dir_dy(nxt_dir[2:0]);
                        end else begin
                            state_d        = ST_COUNT;
                            cnt_idx_d      = 6'd0;
                            shadow_black_d = 7'd0;
                            shadow_white_d = 7'd0;
                        end
                    end else begin
                        run_d = run_q + 3'd1;
                        px_d  = px_q + dir_dx(dir_q);
                        py_d  = py_q + dir_dy(dir_q);
                    end
                end

                ST_COUNT: begin
                    if (cnt_idx_q == 6'd63) begin
                        black_count_d = black_total;
                        white_count_d = white_total;
                        win_d         = game_over;
                        winner_d      = game_over ? final_winner : 2'b00;
                        legal_d       = ok_q;
                        state_d       = ST_FINISH;
                    end else begin
                        cnt_idx_d      = cnt_idx_q + 6'd1;
                        shadow_black_d = black_total;
                        shadow_white_d = white_total;
                    end
                end

                ST_FINISH: begin
                    state_d = ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and board registers with asynchronous reset to the opening position
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            board_q        <= opening_board();
            x_q            <= 3'd0;
            y_q            <= 3'd0;
            side_q         <= 1'b0;
            place_op_q     <= 1'b0;
            dir_q          <= 3'd0;
            run_q          <= 3'd0;
            px_q           <= 5'd0;
            py_q           <= 5'd0;
            dir_mask_q     <= 8'd0;
            run_arr_q      <= '0;
            ok_q           <= 1'b0;
            cnt_idx_q      <= 6'd0;
            shadow_black_q <= 7'd0;
            shadow_white_q <= 7'd0;
            legal_q        <= 1'b0;
            black_count_q  <= 7'd2;
            white_count_q  <= 7'd2;
            win_q          <= 1'b0;
            winner_q       <= 2'b00;
        end else begin
            state_q        <= state_d;
            board_q        <= board_d;
            x_q            <= x_d;
            y_q            <= y_d;
            side_q         <= side_d;
            place_op_q     <= place_op_d;
            dir_q          <= dir_d;
            run_q          <= run_d;
            px_q           <= px_d;
            py_q           <= py_d;
            dir_mask_q     <= dir_mask_d;
            run_arr_q      <= run_arr_d;
            ok_q           <= ok_d;
            cnt_idx_q      <= cnt_idx_d;
            shadow_black_q <= shadow_black_d;
            shadow_white_q <= shadow_white_d;
            legal_q        <= legal_d;
            black_count_q  <= black_count_d;
            white_count_q  <= white_count_d;
            win_q          <= win_d;
            winner_q       <= winner_d;
        end
    end

    assign rd_cell     = board_q[{rd_y, rd_x}];
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_FINISH) && !new_game;
    assign legal       = legal_q;
    assign black_count = black_count_q;
    assign white_count = white_count_q;
    assign win         = win_q;
    assign winner      = winner_q;

endmodule

// File: tb/tb_board_engine.sv
// tb_board_engine: directed scenarios for board_engine with hand-computed
// latencies, counts and board contents.
module tb_board_engine;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       new_game;
    logic [2:0] cur_x, cur_y;
    logic       side, detect, place;
    logic [2:0] rd_x, rd_y;
    logic [1:0] rd_cell;
    logic       busy, done, legal, win;
    logic [6:0] black_count, white_count;
    logic [1:0] winner;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_board [64];

    board_engine dut (
        .clk(clk), .reset_n(reset_n), .new_game(new_game),
        .cur_x(cur_x), .cur_y(cur_y), .side(side),
        .detect(detect), .place(place),
        .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_cell),
        .busy(busy), .done(done), .legal(legal),
        .black_count(black_count), .white_count(white_count),
        .win(win), .winner(winner)
    );

    always #5 clk = ~clk;

    function automatic void set_opening();
        for (int i = 0; i < 64; i++) exp_board[i] = 2'b00;
        exp_board[27] = 2'b10;
        exp_board[36] = 2'b10;
        exp_board[28] = 2'b01;
        exp_board[35] = 2'b01;
    endfunction

    function automatic void put(input int x, input int y, input logic [1:0] v);
        exp_board[y*8 + x] = v;
    endfunction

    // Issue one command and return cycles from accept edge to the done cycle (-1 on timeout)
    task automatic issue(input logic is_place, input logic [2:0] x, input logic [2:0] y,
                         input logic s, output int lat);
        @(negedge clk);
        cur_x = x; cur_y = y; side = s;
        place = is_place; detect = !is_place;
        @(posedge clk);
        #1;
        place = 1'b0; detect = 1'b0;
        lat = -1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic pulse_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; new_game = 1'b0; detect = 1'b0; place = 1'b0;
        cur_x = 3'd0; cur_y = 3'd0; side = 1'b0; rd_x = 3'd0; rd_y = 3'd0;
        set_opening();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (legal !== 1'b0) begin errors++; $display("[TB] FAIL reset_legal: got %b expected 0", legal); end
        checks++; if (black_count !== 7'd2) begin errors++; $display("[TB] FAIL reset_black: got %0d expected 2", black_count); end
        checks++; if (white_count !== 7'd2) begin errors++; $display("[TB] FAIL reset_white: got %0d expected 2", white_count); end
        checks++; if (win !== 1'b0) begin errors++; $display("[TB] FAIL reset_win: got %b expected 0", win); end
        checks++; if (winner !== 2'b00) begin errors++; $display("[TB] FAIL reset_winner: got %b expected 00", winner); end
        for (int i = 0; i < 64; i++) begin
            rd_x = 3'(i % 8); rd_y = 3'(i / 8);
            #2;
            checks++;
            if (rd_cell !== exp_board[i]) begin errors++; $display("[TB] FAIL reset_cell_x%0d_y%0d: got %b expected %b", i % 8, i / 8, rd_cell, exp_board[i]); end
        end
    endtask

    task automatic test_detect();
        int lat;
        issue(1'b0, 3'd3, 3'd2, 1'b0, lat);
        checks++; if (lat != 10) begin errors++; $display("[TB] FAIL detect_legal_latency: got %0d expected 10", lat); end
        checks++; if (legal !== 1'b1) begin errors++; $display("[TB] FAIL detect_legal: got %b expected 1", legal); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL detect_busy_in_done: got %b expected 1", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL detect_busy_after: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL detect_done_after: got %b expected 0", done); end
        checks++; if (black_count !== 7'd2 || white_count !== 7'd2) begin errors++; $display("[TB] FAIL detect_counts: got %0d/%0d expected 2/2", black_count, white_count); end
        for (int i = 0; i < 64; i++) begin
            rd_x = 3'(i % 8); rd_y = 3'(i / 8);
            #2;
            checks++;
            if (rd_cell !== exp_board[i]) begin errors++; $display("[TB] FAIL detect_cell_x%0d_y%0d: got %b expected %b", i % 8, i / 8, rd_cell, exp_board[i]); end
        end
        issue(1'b0, 3'd0, 3'd0, 1'b0, lat);
        checks++; if (lat != 9) begin errors++; $display("[TB] FAIL detect_corner_latency: got %0d expected 9", lat); end
        checks++; if (legal !== 1'b0) begin errors++; $display("[TB] FAIL detect_corner_legal: got %b expected 0", legal); end
    endtask

    task automatic test_place();
        int lat;
        issue(1'b1, 3'd3, 3'd2, 1'b0, lat);
        put(3, 2, 2'b01); put(3, 3, 2'b01);
        checks++; if (lat != 76) begin errors++; $display("[TB] FAIL place_latency: got %0d expected 76", lat); end
        checks++; if (legal !== 1'b1) begin errors++; $display("[TB] FAIL place_legal: got %b expected 1", legal); end
        checks++; if (black_count !== 7'd4) begin errors++; $display("[TB] FAIL place_black: got %0d expected 4", black_count); end
        checks++; if (white_count !== 7'd1) begin errors++; $display("[TB] FAIL place_white: got %0d expected 1", white_count); end
        checks++; if (win !== 1'b0) begin errors++; $display("[TB] FAIL place_win: got %b expected 0", win); end
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            rd_x = 3'(i % 8); rd_y = 3'(i / 8);
            #2;
            checks++;
            if (rd_cell !== exp_board[i]) begin errors++; $display("[TB] FAIL place_cell_x%0d_y%0d: got %b expected %b", i % 8, i / 8, rd_cell, exp_board[i]); end
        end
    endtask

    task automatic test_occupied();
        int lat;
        issue(1'b1, 3'd3, 3'd3, 1'b0, lat);
        checks++; if (lat != 10) begin errors++; $display("[TB] FAIL occupied_latency: got %0d expected 10", lat); end
        checks++; if (legal !== 1'b0) begin errors++; $display("[TB] FAIL occupied_legal: got %b expected 0", legal); end
        checks++; if (black_count !== 7'd4 || white_count !== 7'd1) begin errors++; $display("[TB] FAIL occupied_counts: got %0d/%0d expected 4/1", black_count, white_count); end
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            rd_x = 3'(i % 8); rd_y = 3'(i / 8);
            #2;
            checks++;
            if (rd_cell !== exp_board[i]) begin errors++; $display("[TB] FAIL occupied_cell_x%0d_y%0d: got %b expected %b", i % 8, i / 8, rd_cell, exp_board[i]); end
        end
    endtask

    task automatic test_multi_flip();
        int lat;
        pulse_new_game();
        set_opening();
        issue(1'b1, 3'd3, 3'd2, 1'b0, lat);
        put(3, 2, 2'b01); put(3, 3, 2'b01);
        checks++; if (lat != 76) begin errors++; $display("[TB] FAIL multi_b32_latency: got %0d expected 76", lat); end
        issue(1'b1, 3'd2, 3'd2, 1'b1, lat);
        put(2, 2, 2'b10); put(3, 3, 2'b10);
        checks++; if (lat != 77) begin errors++; $display("[TB] FAIL multi_w22_latency: got %0d expected 77", lat); end
        checks++; if (black_count !== 7'd3 || white_count !== 7'd3) begin errors++; $display("[TB] FAIL multi_w22_counts: got %0d/%0d expected 3/3", black_count, white_count); end
        issue(1'b1, 3'd4, 3'd2, 1'b1, lat);
        put(4, 2, 2'b10); put(4, 3, 2'b10); put(3, 2, 2'b10);
        checks++; if (lat != 78) begin errors++; $display("[TB] FAIL multi_w42_latency: got %0d expected 78", lat); end
        checks++; if (black_count !== 7'd1 || white_count !== 7'd6) begin errors++; $display("[TB] FAIL multi_w42_counts: got %0d/%0d expected 1/6", black_count, white_count); end
        issue(1'b1, 3'd3, 3'd1, 1'b0, lat);
        put(3, 1, 2'b01); put(3, 2, 2'b01); put(3, 3, 2'b01);
        checks++; if (lat != 80) begin errors++; $display("[TB] FAIL multi_b31_latency: got %0d expected 80", lat); end
        checks++; if (legal !== 1'b1) begin errors++; $display("[TB] FAIL multi_b31_legal: got %b expected 1", legal); end
        checks++; if (black_count !== 7'd4 || white_count !== 7'd4) begin errors++; $display("[TB] FAIL multi_b31_counts: got %0d/%0d expected 4/4", black_count, white_count); end
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            rd_x = 3'(i % 8); rd_y = 3'(i / 8);
            #2;
            checks++;
            if (rd_cell !== exp_board[i]) begin errors++; $display("[TB] FAIL multi_cell_x%0d_y%0d: got %b expected %b", i % 8, i / 8, rd_cell, exp_board[i]); end
        end
    endtask

    task automatic test_win();
        int lat;
        pulse_new_game();
        set_opening();
        issue(1'b1, 3'd4, 3'd2, 1'b1, lat);
        put(4, 2, 2'b10); put(4, 3, 2'b10);
        checks++; if (lat != 76) begin errors++; $display("[TB] FAIL win_w42_latency: got %0d expected 76", lat); end
        checks++; if (black_count !== 7'd1 || white_count !== 7'd4) begin errors++; $display("[TB] FAIL win_w42_counts: got %0d/%0d expected 1/4", black_count, white_count); end
        issue(1'b1, 3'd3, 3'd5, 1'b1, lat);
        put(3, 5, 2'b10); put(3, 4, 2'b10);
        checks++; if (lat != 76) begin errors++; $display("[TB] FAIL win_w35_latency: got %0d expected 76", lat); end
        checks++; if (black_count !== 7'd0) begin errors++; $display("[TB] FAIL win_black: got %0d expected 0", black_count); end
        checks++; if (white_count !== 7'd6) begin errors++; $display("[TB] FAIL win_white: got %0d expected 6", white_count); end
        checks++; if (win !== 1'b1) begin errors++; $display("[TB] FAIL win_flag: got %b expected 1", win); end
        checks++; if (winner !== 2'b10) begin errors++; $display("[TB] FAIL win_winner: got %b expected 10", winner); end
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            rd_x = 3'(i % 8); rd_y = 3'(i / 8);
            #2;
            checks++;
            if (rd_cell !== exp_board[i]) begin errors++; $display("[TB] FAIL win_cell_x%0d_y%0d: got %b expected %b", i % 8, i / 8, rd_cell, exp_board[i]); end
        end
    endtask

    task automatic test_new_game_mid_flip();
        int lat;
        int ndone;
        pulse_new_game();
        set_opening();
        checks++; if (win !== 1'b0 || winner !== 2'b00) begin errors++; $display("[TB] FAIL newgame_clears_win: got %b/%b expected 0/00", win, winner); end
        issue(1'b0, 3'd3, 3'd2, 1'b0, lat);
        checks++; if (legal !== 1'b1) begin errors++; $display("[TB] FAIL newgame_pre_legal: got %b expected 1", legal); end
        @(negedge clk);
        cur_x = 3'd3; cur_y = 3'd2; side = 1'b0; place = 1'b1;
        @(posedge clk);
        #1;
        place = 1'b0;
        for (int c = 1; c <= 11; c++) @(negedge clk);
        rd_x = 3'd3; rd_y = 3'd2;
        #1;
        checks++; if (rd_cell !== 2'b01) begin errors++; $display("[TB] FAIL midflip_written_cell: got %b expected 01", rd_cell); end
        rd_x = 3'd3; rd_y = 3'd3;
        #1;
        checks++; if (rd_cell !== 2'b10) begin errors++; $display("[TB] FAIL midflip_unflipped_cell: got %b expected 10", rd_cell); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midflip_busy: got %b expected 1", busy); end
        new_game = 1'b1;
        @(posedge clk);
        #1;
        new_game = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (legal !== 1'b0) begin errors++; $display("[TB] FAIL abort_legal: got %b expected 0", legal); end
        checks++; if (black_count !== 7'd2 || white_count !== 7'd2) begin errors++; $display("[TB] FAIL abort_counts: got %0d/%0d expected 2/2", black_count, white_count); end
        for (int i = 0; i < 64; i++) begin
            rd_x = 3'(i % 8); rd_y = 3'(i / 8);
            #2;
            checks++;
            if (rd_cell !== exp_board[i]) begin errors++; $display("[TB] FAIL abort_cell_x%0d_y%0d: got %b expected %b", i % 8, i / 8, rd_cell, exp_board[i]); end
        end
        ndone = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        checks++; if (ndone != 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d expected 0", ndone); end
    endtask

    task automatic test_back_to_back();
        int lat;
        int ndone;
        @(negedge clk);
        cur_x = 3'd3; cur_y = 3'd2; side = 1'b0; place = 1'b1; new_game = 1'b1;
        @(negedge clk);
        place = 1'b0; new_game = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL override_busy: got %b expected 0", busy); end
        @(negedge clk);
        detect = 1'b1;
        @(posedge clk);
        #1;
        detect = 1'b0;
        lat = -1;
        ndone = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                if (lat < 0) lat = c;
            end
            if (c == 3) begin
                cur_x = 3'd3; cur_y = 3'd2; side = 1'b0; place = 1'b1; detect = 1'b1;
            end
            if (c == 4) begin
                place = 1'b0; detect = 1'b0;
            end
        end
        checks++; if (ndone != 1) begin errors++; $display("[TB] FAIL busy_ignore_done_count: got %0d expected 1", ndone); end
        checks++; if (lat != 10) begin errors++; $display("[TB] FAIL busy_ignore_latency: got %0d expected 10", lat); end
        checks++; if (black_count !== 7'd2 || white_count !== 7'd2) begin errors++; $display("[TB] FAIL busy_ignore_counts: got %0d/%0d expected 2/2", black_count, white_count); end
        for (int i = 0; i < 64; i++) begin
            rd_x = 3'(i % 8); rd_y = 3'(i / 8);
            #2;
            checks++;
            if (rd_cell !== exp_board[i]) begin errors++; $display("[TB] FAIL busy_ignore_cell_x%0d_y%0d: got %b expected %b", i % 8, i / 8, rd_cell, exp_board[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_detect();
        test_place();
        test_occupied();
        test_multi_flip();
        test_win();
        test_new_game_mid_flip();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
